led_serializer_mc: RTL and testbench

- Parametrised successor to the single-strand WS281x serializer.
- Drives N_CH LED strands in lock-step from one clock.
- Fetches per-LED pixel words through a req/ack handshake, with one-deep prefetch so there are no inter-LED gaps.
- Timing is cycle-count parameters rather than hard-wired 50 MHz constants. Supports 24-bit RGB or 32-bit RGBW, MSB- or LSB-first order, and single-shot or auto-repeat frames.

---
 rtl/led_ser_pkg.sv | 30 +++
 rtl/led_serializer_mc_shifter.sv | 42 ++++
 rtl/led_serializer_mc.sv | 177 +++++++++++++++++
 tb/tb_led_serializer_mc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ser_pkg.sv
// Shared types, timing presets and helpers for the multi-strand
// WS281x serializer.
package led_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH0,
    BIT,
    LATCH
  } stateT;

  localparam int T0H_100    = 35;
  localparam int T1H_100    = 70;
  localparam int TBIT_100   = 125;
  localparam int TLATCH_100 = 5000;

  localparam int T0H_50     = 18;
  localparam int T1H_50     = 35;
  localparam int TBIT_50    = 63;
  localparam int TLATCH_50  = 2500;

  function automatic int highCycles(
    input logic b,
    input int   t0h,
    input int   t1h
  );
    return b ? t1h : t0h;
  endfunction

endpackage

// File: rtl/led_serializer_mc_shifter.sv
// Per-strand pixel holder: current word being shifted out plus
// one prefetched word waiting behind it.
module led_bit_shifter
  import led_ser_pkg::*;
#(
  parameter int BPL = 24
) (
  input  logic           clk50,
  input  logic           rst,
  input  logic           msbFirst,
  input  logic           loadCur,
  input  logic           loadPre,
  input  logic           take,
  input  logic           advance,
  input  logic [BPL-1:0] data,
  output logic           curBit
);

  logic [BPL-1:0] curWord;
  logic [BPL-1:0] preWord;

  always_ff @(posedge clk50) begin
    if (rst) begin
      curWord <= '0;
      preWord <= '0;
    end else begin
      if (loadCur)
        curWord <= data;
      else if (take)
        curWord <= preWord;
      else if (advance)
        curWord <= msbFirst ? (curWord << 1)
                            : (curWord >> 1);
      if (loadPre)
        preWord <= data;
    end
  end

  assign curBit = msbFirst ? curWord[BPL-1]
                           : curWord[0];

endmodule

// File: rtl/led_serializer_mc.sv
// N_CH-strand WS281x serializer with req/ack pixel fetch and
// one-deep prefetch; strands run in lock-step.
module led_serializer_mc
  import led_ser_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int NUM_LEDS  = 120,
  parameter int BPL       = 24,
  parameter int MSB_FIRST = 1,
  parameter int T0H       = T0H_100,
  parameter int T1H       = T1H_100,
  parameter int TBIT      = TBIT_100,
  parameter int TLATCH    = TLATCH_100,
  parameter int CW        = 16
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 repeat_en,
  output logic                 pix_req,
  output logic [15:0]          pix_addr,
  input  logic                 pix_ack,
  input  logic [N_CH*BPL-1:0]  pix_data,
  output logic [N_CH-1:0]      o,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam int BW = $clog2(BPL);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BPL-1);
  localparam logic [15:0]   LAST_LED  = 16'(NUM_LEDS-1);
  localparam logic [CW-1:0] CYC_END   = CW'(TBIT-1);
  localparam logic [CW-1:0] LATCH_END = CW'(TLATCH);

  stateT           state, stateN;
  logic [CW-1:0]   cyc, cycN;
  logic [BW-1:0]   bitCnt, bitCntN;
  logic [15:0]     curLed, curLedN;
  logic [15:0]     addrN;
  logic            reqN;
  logic            preFull, preFullN;
  logic            underrunN;
  logic            loadCur, loadPre, take, advance;
  logic            ackOk, bitEnd, ledEnd;
  logic [N_CH-1:0] curBits;

  assign ackOk  = pix_req & pix_ack;
  assign bitEnd = (cyc == CYC_END);
  assign ledEnd = bitEnd && (bitCnt == LAST_BIT);

  always_comb begin
    stateN    = state;
    cycN      = cyc;
    bitCntN   = bitCnt;
    curLedN   = curLed;
    addrN     = pix_addr;
    reqN      = pix_req;
    preFullN  = preFull;
    underrunN = underrun;
    loadCur   = 1'b0;
    loadPre   = 1'b0;
    take      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateN    = FETCH0;
          addrN     = '0;
          reqN      = 1'b1;
          underrunN = 1'b0;
        end
      end
      FETCH0: begin
        if (ackOk) begin
          loadCur  = 1'b1;
          stateN   = BIT;
          cycN     = '0;
          bitCntN  = '0;
          curLedN  = '0;
          preFullN = 1'b0;
          reqN     = (NUM_LEDS > 1);
          if (NUM_LEDS > 1)
            addrN = 16'd1;
        end
      end
      BIT: begin
        if (ackOk && !ledEnd) begin
          loadPre  = 1'b1;
          preFullN = 1'b1;
          reqN     = 1'b0;
        end
        if (!bitEnd) begin
          cycN = cyc + 1'b1;
        end else if (bitCnt != LAST_BIT) begin
          cycN    = '0;
          bitCntN = bitCnt + 1'b1;
          advance = 1'b1;
        end else if (curLed == LAST_LED) begin
          stateN = LATCH;
          cycN   = '0;
        end else if (preFull || ackOk) begin
          // a late ack goes straight into the shifter
          take     = preFull;
          loadCur  = !preFull;
          preFullN = 1'b0;
          cycN     = '0;
          bitCntN  = '0;
          curLedN  = curLed + 16'd1;
          reqN     = (pix_addr < LAST_LED);
          if (pix_addr < LAST_LED)
            addrN = pix_addr + 16'd1;
        end else begin
          underrunN = 1'b1;
        end
      end
      LATCH: begin
        if (cyc != LATCH_END) begin
          cycN = cyc + 1'b1;
        end else if (repeat_en) begin
          stateN = FETCH0;
          cycN   = '0;
          addrN  = '0;
          reqN   = 1'b1;
        end else begin
          stateN = IDLE;
          cycN   = '0;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state    <= IDLE;
      cyc      <= '0;
      bitCnt   <= '0;
      curLed   <= '0;
      pix_addr <= '0;
      pix_req  <= 1'b0;
      preFull  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= stateN;
      cyc      <= cycN;
      bitCnt   <= bitCntN;
      curLed   <= curLedN;
      pix_addr <= addrN;
      pix_req  <= reqN;
      preFull  <= preFullN;
      underrun <= underrunN;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == LATCH) && (cyc == LATCH_END);

  for (genvar c = 0; c < N_CH; c++) begin : gCh
    led_bit_shifter #(
      .BPL(BPL)
    ) uShift (
      .clk50   (clk50),
      .rst     (rst),
      .msbFirst(MSB_FIRST != 0),
      .loadCur (loadCur),
      .loadPre (loadPre),
      .take    (take),
      .advance (advance),
      .data    (pix_data[c*BPL +: BPL]),
      .curBit  (curBits[c])
    );
    assign o[c] = (state == BIT) &&
      (cyc < CW'(highCycles(curBits[c], T0H, T1H)));
  end

endmodule

// File: tb/tb_led_serializer_mc.sv
// Bench for led_serializer_mc: MSB-first and LSB-first instances
// in lock-step, pulse widths checked against a scoreboard.
module tb_led_serializer_mc;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        repeatEn = 1'b0;
  logic        pixAck = 1'b0;
  logic [47:0] pixData0 = '0;
  logic [47:0] pixData1 = '0;
  logic        pixReq0, pixReq1;
  logic [15:0] pixAddr0, pixAddr1;
  logic [1:0]  o0, o1;
  logic        busy0, busy1, done0, done1;
  logic        under0, under1;

  int nCmp = 0;
  int nErr = 0;
  int sb[4][$];
  int hi[4];
  bit prevO[4];
  int lastW = 35;
  int lowRun;

  always #5 clk50 = ~clk50;

  led_serializer_mc #(
    .N_CH(2), .NUM_LEDS(2), .BPL(24), .MSB_FIRST(1)
  ) dut0 (
    .clk50(clk50), .rst(rst), .start(start),
    .repeat_en(repeatEn), .pix_req(pixReq0),
    .pix_addr(pixAddr0), .pix_ack(pixAck),
    .pix_data(pixData0), .o(o0), .busy(busy0),
    .done(done0), .underrun(under0)
  );

  led_serializer_mc #(
    .N_CH(2), .NUM_LEDS(2), .BPL(24), .MSB_FIRST(0)
  ) dut1 (
    .clk50(clk50), .rst(rst), .start(start),
    .repeat_en(repeatEn), .pix_req(pixReq1),
    .pix_addr(pixAddr1), .pix_ack(pixAck),
    .pix_data(pixData1), .o(o1), .busy(busy1),
    .done(done1), .underrun(under1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pushWord(
    input int          s,
    input logic [23:0] w,
    input bit          msb
  );
    int b;
    int wd;
    for (int i = 0; i < 24; i++) begin
      b  = msb ? 23 - i : i;
      wd = w[b] ? 70 : 35;
      sb[s].push_back(wd);
      if (s == 0) lastW = wd;
    end
  endtask

  task automatic ackLed(
    input logic [15:0] addr,
    input int          dly,
    input logic [23:0] a0,
    input logic [23:0] a1,
    input logic [23:0] b0,
    input logic [23:0] b1
  );
    bit got = 0;
    for (int i = 0; i < 2000; i++) begin
      if (pixReq0) begin
        got = 1;
        break;
      end
      @(posedge clk50); #1;
    end
    chk("reqSeen", 32'(got), 1);
    chk("reqAddr0", 32'(pixAddr0), 32'(addr));
    chk("reqLsb", 32'({pixReq1, pixAddr1}),
        32'({1'b1, addr}));
    repeat (dly) begin
      @(posedge clk50); #1;
    end
    pixAck   = 1'b1;
    pixData0 = {a1, a0};
    pixData1 = {b1, b0};
    pushWord(0, a0, 1);
    pushWord(1, a1, 1);
    pushWord(2, b0, 0);
    pushWord(3, b1, 0);
    @(posedge clk50); #1;
    pixAck = 1'b0;
  endtask

  task automatic waitDone(output int lr);
    bit got = 0;
    lr = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk50);
      if (done0) begin
        got = 1;
        break;
      end
      if (o0[0]) lr = 0;
      else lr++;
    end
    chk("doneSeen", 32'(got), 1);
    chk("doneLsb", 32'(done1), 1);
    chk("busyAtDone", 32'(busy0), 1);
    chk("latchLow", 32'(lr), 32'(125 - lastW + 5000));
  endtask

  task automatic pulseStart;
    @(posedge clk50); #1;
    start = 1'b1;
    @(posedge clk50); #1;
    start = 1'b0;
  endtask

  always @(negedge clk50) begin
    logic [3:0] v;
    int e;
    v = {o1, o0};
    for (int s = 0; s < 4; s++) begin
      if (rst) begin
        hi[s]    = 0;
        prevO[s] = 0;
      end else begin
        if (v[s]) begin
          hi[s]++;
        end else if (prevO[s]) begin
          if (sb[s].size() != 0) e = sb[s].pop_front();
          else e = -1;
          chk($sformatf("width%0d", s), hi[s], e);
          hi[s] = 0;
        end
        prevO[s] = v[s];
      end
    end
  end

  initial begin
    // reset values
    repeat (3) @(posedge clk50);
    #1;
    chk("rstO", 32'({o1, o0}), 0);
    chk("rstReq", 32'({pixReq1, pixReq0}), 0);
    chk("rstAddr", 32'(pixAddr0), 0);
    chk("rstBusy", 32'({busy1, busy0}), 0);
    chk("rstDone", 32'({done1, done0}), 0);
    chk("rstUnder", 32'({under1, under0}), 0);
    rst = 1'b0;

    // frame A: basic, stray ack, ignored start, repeat
    repeatEn = 1'b1;
    pulseStart();
    chk("startBusy", 32'(busy0), 1);
    ackLed(16'd0, 2, 24'h800001, 24'h000000,
           24'h000001, 24'h800000);
    ackLed(16'd1, 3, 24'h5A5A5A, 24'hFFFFFF,
           24'h123456, 24'h0F0F0F);
    pixAck   = 1'b1;
    pixData0 = '0;
    pixData1 = '0;
    @(posedge clk50); #1;
    pixAck = 1'b0;
    repeat (500) @(posedge clk50);
    #1;
    start = 1'b1;
    @(posedge clk50); #1;
    start = 1'b0;
    chk("ignAddr", 32'(pixAddr0), 1);
    chk("ignReq", 32'(pixReq0), 0);
    chk("ignBusy", 32'(busy0), 1);
    waitDone(lowRun);
    @(posedge clk50); #1;
    chk("donePulse", 32'(done0), 0);
    chk("rptReq", 32'(pixReq0), 1);
    chk("rptAddr", 32'(pixAddr0), 0);
    chk("rptBusy", 32'(busy0), 1);
    repeatEn = 1'b0;

    // frame B: underrun on LED 1
    ackLed(16'd0, 1, 24'hA5F00F, 24'h3C3C3C,
           24'h000001, 24'hFFFFFF);
    begin
      bit got = 0;
      for (int i = 0; i < 3200; i++) begin
        @(posedge clk50); #1;
        if (under0) begin
          got = 1;
          break;
        end
      end
      chk("underSeen", 32'(got), 1);
    end
    begin
      logic [1:0] any = '0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk50); #1;
        any = any | o0;
      end
      chk("underLow", 32'(any), 0);
    end
    chk("underFlag", 32'({under1, under0}), 2'b11);
    ackLed(16'd1, 0, 24'hC00003, 24'h00FF00,
           24'h800000, 24'h555555);
    waitDone(lowRun);
    @(posedge clk50); #1;
    chk("endBusy", 32'(busy0), 0);
    chk("underSticky", 32'(under0), 1);

    // frame C: reset during bit 10 of LED 0
    pulseStart();
    chk("underClr", 32'(under0), 0);
    ackLed(16'd0, 0, 24'h800001, 24'h000000,
           24'h000001, 24'h000000);
    ackLed(16'd1, 2, 24'hFFFFFF, 24'hFFFFFF,
           24'hFFFFFF, 24'hFFFFFF);
    repeat (1260) @(posedge clk50);
    #1;
    chk("preRstBusy", 32'(busy0), 1);
    rst = 1'b1;
    @(posedge clk50); #1;
    chk("midRstO", 32'({o1, o0}), 0);
    chk("midRstReq", 32'(pixReq0), 0);
    chk("midRstBusy", 32'(busy0), 0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) sb[s].delete();

    // frame D: clean frame after reset
    pulseStart();
    ackLed(16'd0, 1, 24'hC3A5FF, 24'h000001,
           24'h0000F0, 24'hAAAAAA);
    ackLed(16'd1, 1, 24'h7E0081, 24'hFEDCBA,
           24'h010203, 24'h808080);
    waitDone(lowRun);
    @(posedge clk50); #1;
    chk("finBusy", 32'(busy0), 0);
    chk("finReq", 32'(pixReq0), 0);
    for (int s = 0; s < 4; s++)
      chk($sformatf("sbEmpty%0d", s), sb[s].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
